// File: rtl/fpga2cpu_pcie_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fpga2cpu_pcie_if
// Brief    : Bundles the FPGA-to-CPU PCIe producer's flit input, ring indices,
//            write-data-mover descriptor channel, endpoint buffer write port
//            and statistics.
//            master = producer block, slave = its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface fpga2cpu_pcie_if #(
  parameter int F2C_RB_AWIDTH = 9,
  parameter int MAX_FLITS     = 32
);
  localparam int EP_AW = $clog2(MAX_FLITS);

  // Packet flit stream
  logic [511:0]             in_data;
  logic                     in_valid;
  logic                     in_sop;
  logic                     in_eop;
  logic                     in_ready;

  // Ring indices and host addresses
  logic [F2C_RB_AWIDTH-1:0] head;
  logic [F2C_RB_AWIDTH-1:0] tail;
  logic [63:0]              kmem_addr;
  logic [63:0]              cpu_f2c_tail_addr;

  // Write data mover descriptor channel
  logic                     wrdm_desc_ready;
  logic                     wrdm_desc_valid;
  logic [173:0]             wrdm_desc_data;

  // Endpoint buffer write port
  logic                     ep_write;
  logic [EP_AW-1:0]         ep_address;
  logic [511:0]             ep_writedata;

  // Statistics
  logic [31:0]              pkt_cnt;
  logic [31:0]              drop_cnt;

  modport master (
    input  in_data, in_valid, in_sop, in_eop,
    input  head, kmem_addr, cpu_f2c_tail_addr,
    input  wrdm_desc_ready,
    output in_ready, tail,
    output wrdm_desc_valid, wrdm_desc_data,
    output ep_write, ep_address, ep_writedata,
    output pkt_cnt, drop_cnt
  );

  modport slave (
    output in_data, in_valid, in_sop, in_eop,
    output head, kmem_addr, cpu_f2c_tail_addr,
    output wrdm_desc_ready,
    input  in_ready, tail,
    input  wrdm_desc_valid, wrdm_desc_data,
    input  ep_write, ep_address, ep_writedata,
    input  pkt_cnt, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fpga2cpu_pcie.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fpga2cpu_pcie
// Brief    : Buffers one packet of 512-bit flits in an endpoint buffer, copies
//            it into the host F2C ring with one or two write-data-mover
//            descriptors (two when it wraps), then publishes the new tail with
//            an immediate descriptor.
// Revision : 1.0 - initial release
// ============================================================================
module fpga2cpu_pcie #(
  parameter int          F2C_RB_AWIDTH = 9,
  parameter int          MAX_FLITS     = 32,
  parameter logic [31:0] EP_BASE_ADDR  = 32'h0004_8000,
  parameter logic [7:0]  DESC_ID       = 8'h01,
  parameter logic [7:0]  DONE_ID       = 8'hFE
) (
  input  logic            clk,
  input  logic            rst,
  fpga2cpu_pcie_if.master bus
);

  localparam int F2C_RB_DEPTH = 2**F2C_RB_AWIDTH;
  localparam int EP_AW        = $clog2(MAX_FLITS);
  // Flit counter width: must be able to hold MAX_FLITS itself
  localparam int CW           = $clog2(MAX_FLITS + 1);
  // Width for ring sums / lengths (tail + n may reach 2*DEPTH-1)
  localparam int SW           = ((F2C_RB_AWIDTH > CW) ? F2C_RB_AWIDTH : CW) + 1;

  localparam logic [SW-1:0] c_DEPTH   = SW'(F2C_RB_DEPTH);
  localparam logic [CW-1:0] c_MAX_CNT = CW'(MAX_FLITS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL      = 3'd1,
    S_CHECK     = 3'd2,
    S_DESC      = 3'd3,
    S_DESC_LOW  = 3'd4,
    S_DESC_HIGH = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;

  logic [CW-1:0]            r_flit_cnt;
  logic [CW-1:0]            r_n;
  logic                     r_trunc;
  logic [F2C_RB_AWIDTH-1:0] r_tail;
  logic [F2C_RB_AWIDTH-1:0] r_new_tail;
  logic [SW-1:0]            r_len_low;
  logic [SW-1:0]            r_len_high;
  logic                     r_in_ready;
  logic                     r_desc_valid;
  logic [173:0]             r_desc_data;
  logic                     r_ep_write;
  logic [EP_AW-1:0]         r_ep_address;
  logic [511:0]             r_ep_writedata;
  logic [31:0]              r_pkt_cnt;
  logic [31:0]              r_drop_cnt;

  logic                     w_accept;
  logic                     w_consume;
  logic [F2C_RB_AWIDTH-1:0] w_free;
  logic                     w_fits;
  logic [SW-1:0]            w_sum;
  logic                     w_split;
  logic [SW-1:0]            w_len_low;
  logic [CW-1:0]            w_n_eop;
  logic [63:0]              w_dst_tail;
  logic [173:0]             w_desc_next;
  logic                     w_desc_active_next;

  // Descriptor layout, MSB first: one zero pad bit (fills the 174-bit bus),
  // function, ID, application, single, immediate, dwords, dst, src.
  function automatic logic [173:0] f_desc(
    input logic [7:0]  id,
    input logic        single,
    input logic        imm,
    input logic [17:0] dwords,
    input logic [63:0] dst,
    input logic [63:0] src
  );
    return {1'b0, 14'h0, id, 3'b000, single, imm, dwords, dst, src};
  endfunction

  // One 64-byte flit is 16 dwords
  function automatic logic [17:0] f_dwords(input logic [SW-1:0] flits);
    return 18'({flits, 4'b0000});
  endfunction

  // Avalon source address of a flit offset within the endpoint buffer
  function automatic logic [63:0] f_ep_src(input logic [SW-1:0] off);
    return {32'h0, EP_BASE_ADDR + 32'({off, 6'b000000})};
  endfunction

  assign w_accept   = bus.in_valid & r_in_ready;
  assign w_consume  = r_desc_valid & bus.wrdm_desc_ready;

  // Free slots keep one entry empty so head == tail always means "empty"
  assign w_free     = bus.head - r_tail - 1'b1;
  assign w_fits     = SW'(r_n) <= SW'(w_free);
  assign w_sum      = SW'(r_tail) + SW'(r_n);
  // Landing exactly on the ring end is not a split; only overruns are
  assign w_split    = w_sum > c_DEPTH;
  assign w_len_low  = c_DEPTH - SW'(r_tail);
  assign w_n_eop    = (r_flit_cnt == c_MAX_CNT) ? c_MAX_CNT : r_flit_cnt + CW'(1);
  assign w_dst_tail = bus.kmem_addr + 64'({r_tail, 6'b000000});

  // Next-state and next-descriptor selection
  always_comb begin
    w_state_next = r_state;
    w_desc_next  = r_desc_data;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && bus.in_sop) begin
          w_state_next = bus.in_eop ? S_CHECK : S_FILL;
        end
      end
      S_FILL: begin
        if (w_accept && bus.in_eop) begin
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_fits) begin
          if (w_split) begin
            w_state_next = S_DESC_LOW;
            w_desc_next  = f_desc(DESC_ID, 1'b0, 1'b0, f_dwords(w_len_low),
                                  w_dst_tail, f_ep_src('0));
          end else begin
            w_state_next = S_DESC;
            w_desc_next  = f_desc(DESC_ID, 1'b0, 1'b0, f_dwords(SW'(r_n)),
                                  w_dst_tail, f_ep_src('0));
          end
        end
      end
      S_DESC, S_DESC_HIGH: begin
        if (w_consume) begin
          w_state_next = S_DONE;
          w_desc_next  = f_desc(DONE_ID, 1'b1, 1'b1, 18'd1,
                                bus.cpu_f2c_tail_addr, 64'(r_new_tail));
        end
      end
      S_DESC_LOW: begin
        if (w_consume) begin
          w_state_next = S_DESC_HIGH;
          w_desc_next  = f_desc(DESC_ID, 1'b0, 1'b0, f_dwords(r_len_high),
                                bus.kmem_addr, f_ep_src(r_len_low));
        end
      end
      S_DONE: begin
        if (w_consume) begin
          w_state_next = S_IDLE;
          w_desc_next  = '0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_desc_next  = '0;
      end
    endcase
  end

  assign w_desc_active_next = (w_state_next == S_DESC)      ||
                              (w_state_next == S_DESC_LOW)  ||
                              (w_state_next == S_DESC_HIGH) ||
                              (w_state_next == S_DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Handshake outputs follow the next state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready   <= 1'b0;
      r_desc_valid <= 1'b0;
      r_desc_data  <= '0;
    end else begin
      r_in_ready   <= (w_state_next == S_IDLE) || (w_state_next == S_FILL);
      r_desc_valid <= w_desc_active_next;
      r_desc_data  <= w_desc_next;
    end
  end

  // Flit capture into the endpoint buffer, with truncation beyond MAX_FLITS
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ep_write     <= 1'b0;
      r_ep_address   <= '0;
      r_ep_writedata <= '0;
      r_flit_cnt     <= '0;
      r_n            <= '0;
      r_trunc        <= 1'b0;
    end else begin
      r_ep_write <= 1'b0;
      if (w_accept && (r_state == S_IDLE) && bus.in_sop) begin
        r_ep_write     <= 1'b1;
        r_ep_address   <= '0;
        r_ep_writedata <= bus.in_data;
        r_flit_cnt     <= CW'(1);
        r_trunc        <= 1'b0;
        if (bus.in_eop) begin
          r_n <= CW'(1);
        end
      end else if (w_accept && (r_state == S_FILL)) begin
        if (r_flit_cnt < c_MAX_CNT) begin
          r_ep_write     <= 1'b1;
          r_ep_address   <= EP_AW'(r_flit_cnt);
          r_ep_writedata <= bus.in_data;
          r_flit_cnt     <= r_flit_cnt + CW'(1);
        end else begin
          r_trunc <= 1'b1;
        end
        if (bus.in_eop) begin
          r_n <= w_n_eop;
        end
      end
    end
  end

  // Ring placement is latched when the packet is admitted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_new_tail <= '0;
      r_len_low  <= '0;
      r_len_high <= '0;
    end else if ((r_state == S_CHECK) && w_fits) begin
      r_new_tail <= w_sum[F2C_RB_AWIDTH-1:0];
      r_len_low  <= w_len_low;
      r_len_high <= SW'(r_n) - w_len_low;
    end
  end

  // Publish tail and statistics when the done descriptor is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tail     <= '0;
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if ((r_state == S_DONE) && w_consume) begin
      r_tail    <= r_new_tail;
      r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (r_trunc) begin
        r_drop_cnt <= r_drop_cnt + 32'd1;
      end
    end
  end

  assign bus.in_ready        = r_in_ready;
  assign bus.tail            = r_tail;
  assign bus.wrdm_desc_valid = r_desc_valid;
  assign bus.wrdm_desc_data  = r_desc_data;
  assign bus.ep_write        = r_ep_write;
  assign bus.ep_address      = r_ep_address;
  assign bus.ep_writedata    = r_ep_writedata;
  assign bus.pkt_cnt         = r_pkt_cnt;
  assign bus.drop_cnt        = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fpga2cpu_pcie.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fpga2cpu_pcie
// Brief    : Directed self-checking bench for fpga2cpu_pcie.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpga2cpu_pcie;

  localparam logic [63:0] c_KMEM  = 64'h0000_0001_2340_0000;
  localparam logic [63:0] c_TADDR = 64'h0000_0001_5550_0040;
  localparam logic [7:0]  c_DID   = 8'h01;
  localparam logic [7:0]  c_FID   = 8'hFE;

  logic clk;
  logic rst;

  fpga2cpu_pcie_if #(.F2C_RB_AWIDTH(9), .MAX_FLITS(32)) bus ();

  fpga2cpu_pcie #(
    .F2C_RB_AWIDTH(9),
    .MAX_FLITS    (32),
    .EP_BASE_ADDR (32'h0004_8000),
    .DESC_ID      (8'h01),
    .DONE_ID      (8'hFE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int m_tail   = 0;
  int m_pkt    = 0;
  int pid      = 0;

  logic [173:0] desc_q[$];
  int           epa_q[$];
  logic [511:0] epd_q[$];

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [173:0] mk(input logic [7:0] id, input logic s, input logic im,
                                      input logic [17:0] dw, input logic [63:0] dst,
                                      input logic [63:0] src);
    return {1'b0, 14'h0, id, 3'b000, s, im, dw, dst, src};
  endfunction

  function automatic logic [511:0] flit(input int p, input int idx);
    logic [15:0] a;
    logic [15:0] b;
    a = p[15:0];
    b = idx[15:0];
    return {16{a, b}};
  endfunction

  function automatic logic [173:0] qd(input int i);
    return (desc_q.size() > i) ? desc_q[i] : '0;
  endfunction

  // Capture consumed descriptors and endpoint writes away from the clock edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wrdm_desc_valid && bus.wrdm_desc_ready) desc_q.push_back(bus.wrdm_desc_data);
      if (bus.ep_write) begin
        epa_q.push_back(int'(bus.ep_address));
        epd_q.push_back(bus.ep_writedata);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_q();
    desc_q.delete();
    epa_q.delete();
    epd_q.delete();
  endtask

  task automatic send_pkt(input int nf, input int p);
    int i;
    int g;
    i = 0;
    g = 0;
    while (i < nf && g < 500) begin
      bus.in_valid = 1'b1;
      bus.in_sop   = (i == 0);
      bus.in_eop   = (i == nf - 1);
      bus.in_data  = flit(p, i);
      @(negedge clk);
      if (bus.in_ready) i++;
      @(posedge clk); #1;
      g++;
    end
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
    if (i < nf) check("send_timeout", i, nf);
  endtask

  task automatic wait_pkt(input int exp);
    int g;
    g = 0;
    while (bus.pkt_cnt != 32'(exp) && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    check("pkt_cnt", bus.pkt_cnt, exp);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid();
    int g;
    g = 0;
    while (!bus.wrdm_desc_valid && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check("valid_seen", bus.wrdm_desc_valid, 1);
  endtask

  task automatic check_reset_state();
    check("rst_tail", bus.tail, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_valid", bus.wrdm_desc_valid, 0);
    check("rst_data", bus.wrdm_desc_data, 0);
    check("rst_ep_write", bus.ep_write, 0);
    check("rst_pkt_cnt", bus.pkt_cnt, 0);
    check("rst_drop_cnt", bus.drop_cnt, 0);
  endtask

  // Advance the ring with full-free filler packets until tail reaches target
  task automatic fill_to(input int target);
    int n;
    int g;
    g = 0;
    while (m_tail != target && g < 64) begin
      n = (target - m_tail + 512) % 512;
      if (n > 32) n = 32;
      bus.head = 9'((m_tail + 511) % 512);
      send_pkt(n, pid);
      pid++;
      m_pkt++;
      wait_pkt(m_pkt);
      m_tail = (m_tail + n) % 512;
      check("fill_tail", bus.tail, m_tail);
      clear_q();
      g++;
    end
  endtask

  task automatic pulse_ready();
    @(posedge clk); #1 bus.wrdm_desc_ready = 1'b1;
    @(posedge clk); #1 bus.wrdm_desc_ready = 1'b0;
  endtask

  initial begin
    int bad;
    rst                   = 1'b1;
    bus.in_data           = '0;
    bus.in_valid          = 1'b0;
    bus.in_sop            = 1'b0;
    bus.in_eop            = 1'b0;
    bus.head              = '0;
    bus.kmem_addr         = c_KMEM;
    bus.cpu_f2c_tail_addr = c_TADDR;
    bus.wrdm_desc_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: basic 4-flit packet
    bus.head = 9'd0;
    send_pkt(4, pid); pid++;
    m_pkt = 1;
    wait_pkt(1);
    check("t1_ep_count", epa_q.size(), 4);
    for (int i = 0; i < 4 && i < epa_q.size(); i++) begin
      check("t1_ep_addr", epa_q[i], i);
      check("t1_ep_data", epd_q[i], flit(0, i));
    end
    check("t1_desc_count", desc_q.size(), 2);
    check("t1_data_desc", qd(0), mk(c_DID, 1'b0, 1'b0, 18'd64, c_KMEM, 64'h48000));
    check("t1_done_desc", qd(1), mk(c_FID, 1'b1, 1'b1, 18'd1, c_TADDR, 64'd4));
    check("t1_tail", bus.tail, 4);
    m_tail = 4;
    clear_q();

    // 2: wrap from tail 510
    fill_to(510);
    bus.head = 9'd100;
    send_pkt(5, pid); pid++;
    m_pkt++;
    wait_pkt(m_pkt);
    check("t2_desc_count", desc_q.size(), 3);
    check("t2_low", qd(0), mk(c_DID, 1'b0, 1'b0, 18'd32, c_KMEM + 64'h7F80, 64'h48000));
    check("t2_high", qd(1), mk(c_DID, 1'b0, 1'b0, 18'd48, c_KMEM, 64'h48080));
    check("t2_done", qd(2), mk(c_FID, 1'b1, 1'b1, 18'd1, c_TADDR, 64'd3));
    check("t2_tail", bus.tail, 3);
    m_tail = 3;
    clear_q();

    // 3: packet ends exactly at ring end
    fill_to(508);
    bus.head = 9'd10;
    send_pkt(4, pid); pid++;
    m_pkt++;
    wait_pkt(m_pkt);
    check("t3_desc_count", desc_q.size(), 2);
    check("t3_data", qd(0), mk(c_DID, 1'b0, 1'b0, 18'd64, c_KMEM + 64'h7F00, 64'h48000));
    check("t3_done", qd(1), mk(c_FID, 1'b1, 1'b1, 18'd1, c_TADDR, 64'd0));
    check("t3_tail", bus.tail, 0);
    m_tail = 0;
    clear_q();

    // 4: ring full stall
    fill_to(10);
    bus.head = 9'd12;
    send_pkt(3, pid); pid++;
    repeat (20) begin @(posedge clk); #1; end
    check("t4_stall_ready", bus.in_ready, 0);
    check("t4_stall_valid", bus.wrdm_desc_valid, 0);
    check("t4_stall_descs", desc_q.size(), 0);
    check("t4_stall_pkt", bus.pkt_cnt, m_pkt);
    bus.head = 9'd20;
    m_pkt++;
    wait_pkt(m_pkt);
    check("t4_data", qd(0), mk(c_DID, 1'b0, 1'b0, 18'd48, c_KMEM + 64'h280, 64'h48000));
    check("t4_done", qd(1), mk(c_FID, 1'b1, 1'b1, 18'd1, c_TADDR, 64'd13));
    check("t4_tail", bus.tail, 13);
    m_tail = 13;
    clear_q();

    // 5: descriptor backpressure
    bus.wrdm_desc_ready = 1'b0;
    bus.head = 9'd12;
    send_pkt(2, pid); pid++;
    wait_valid();
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.wrdm_desc_valid !== 1'b1 ||
          bus.wrdm_desc_data !== mk(c_DID, 1'b0, 1'b0, 18'd32, c_KMEM + 64'h340, 64'h48000)) bad++;
    end
    check("t5_desc_stable", bad, 0);
    pulse_ready();
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.wrdm_desc_valid !== 1'b1 ||
          bus.wrdm_desc_data !== mk(c_FID, 1'b1, 1'b1, 18'd1, c_TADDR, 64'd15)) bad++;
    end
    check("t5_done_stable", bad, 0);
    @(posedge clk); #1 bus.wrdm_desc_ready = 1'b1;
    m_pkt++;
    wait_pkt(m_pkt);
    check("t5_desc_count", desc_q.size(), 2);
    check("t5_data", qd(0), mk(c_DID, 1'b0, 1'b0, 18'd32, c_KMEM + 64'h340, 64'h48000));
    check("t5_done", qd(1), mk(c_FID, 1'b1, 1'b1, 18'd1, c_TADDR, 64'd15));
    check("t5_valid_low", bus.wrdm_desc_valid, 0);
    check("t5_tail", bus.tail, 15);
    m_tail = 15;
    clear_q();

    // 6a: 40-flit packet truncated to 32
    bus.head = 9'd14;
    send_pkt(40, pid); pid++;
    m_pkt++;
    wait_pkt(m_pkt);
    check("t6_ep_count", epa_q.size(), 32);
    check("t6_ep_last_addr", (epa_q.size() == 32) ? epa_q[31] : -1, 31);
    check("t6_ep_last_data", (epd_q.size() == 32) ? epd_q[31] : '0, flit(pid - 1, 31));
    check("t6_data", qd(0), mk(c_DID, 1'b0, 1'b0, 18'd512, c_KMEM + 64'h3C0, 64'h48000));
    check("t6_done", qd(1), mk(c_FID, 1'b1, 1'b1, 18'd1, c_TADDR, 64'd47));
    check("t6_drop_cnt", bus.drop_cnt, 1);
    check("t6_tail", bus.tail, 47);
    m_tail = 47;
    clear_q();

    // 6b: reset while DESC_HIGH is pending
    fill_to(500);
    bus.wrdm_desc_ready = 1'b0;
    bus.head = 9'd499;
    send_pkt(20, pid); pid++;
    wait_valid();
    check("t6_low", bus.wrdm_desc_data, mk(c_DID, 1'b0, 1'b0, 18'd192, c_KMEM + 64'h7D00, 64'h48000));
    pulse_ready();
    @(negedge clk);
    check("t6_high_valid", bus.wrdm_desc_valid, 1);
    check("t6_high", bus.wrdm_desc_data, mk(c_DID, 1'b0, 1'b0, 18'd128, c_KMEM, 64'h48300));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state();
    rst = 1'b0;
    bus.wrdm_desc_ready = 1'b1;
    m_tail = 0;
    m_pkt  = 0;
    clear_q();
    @(posedge clk); #1;

    // Single-flit packet after reset
    bus.head = 9'd0;
    send_pkt(1, pid); pid++;
    m_pkt = 1;
    wait_pkt(1);
    check("t7_ep_count", epa_q.size(), 1);
    check("t7_data", qd(0), mk(c_DID, 1'b0, 1'b0, 18'd16, c_KMEM, 64'h48000));
    check("t7_done", qd(1), mk(c_FID, 1'b1, 1'b1, 18'd1, c_TADDR, 64'd1));
    check("t7_tail", bus.tail, 1);
    check("t7_drop_cnt", bus.drop_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpga2cpu_pcie.md
Name: fpga2cpu_pcie

Overview:
FPGA-to-CPU PCIe producer. It buffers one packet of 512-bit flits in an endpoint memory region and issues write-data-mover descriptors that copy the packet into the CPU-side F2C ring buffer at kmem_addr. It then issues an immediate "done" descriptor that publishes the new tail to host memory. It sits between the FPGA packet/metadata path and the PCIe write data mover; the host consumes the ring and advances head.

Parameters:
F2C_RB_AWIDTH, 9, ring index width; ring depth F2C_RB_DEPTH = 2**F2C_RB_AWIDTH entries of 64 B
MAX_FLITS, 32, endpoint buffer depth in flits (max packet length)
EP_BASE_ADDR, 32'h0004_8000, Avalon-MM base address of the endpoint buffer
DESC_ID, 8'h01, descriptor ID for data descriptors
DONE_ID, 8'hFE, descriptor ID for the tail-update descriptor

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_data  in  512  packet flit
in_valid  in  1  flit valid
in_sop  in  1  first flit of packet
in_eop  in  1  last flit of packet
in_ready  out  1  block accepts flit (valid&&ready)
head  in  F2C_RB_AWIDTH  host consumer index
tail  out  F2C_RB_AWIDTH  producer index
kmem_addr  in  64  host ring base PCIe address
cpu_f2c_tail_addr  in  64  host address receiving the tail value
wrdm_desc_ready  in  1  data mover accepts descriptor
wrdm_desc_valid  out  1  descriptor valid
wrdm_desc_data  out  174  descriptor
ep_write  out  1  endpoint buffer write strobe
ep_address  out  $clog2(MAX_FLITS)  endpoint buffer flit index
ep_writedata  out  512  endpoint buffer data
pkt_cnt  out  32  packets published
drop_cnt  out  32  packets truncated

Behaviour:
- Reset values: tail=0, in_ready=0, wrdm_desc_valid=0, wrdm_desc_data=0, ep_write=0, pkt_cnt=0, drop_cnt=0. Reset mid-operation aborts any packet or descriptor sequence and returns to IDLE; tail returns to 0.
- Descriptor format, MSB to LSB:
  - 14'h0 function
  - 8b ID
  - 3'b0 application
  - 1b single-destination
  - 1b immediate
  - 18b dword count
  - 64b destination PCIe address
  - 64b source Avalon address or immediate data
- Data descriptor: single=0, immediate=0, dwords=16*n, src={32'h0, EP_BASE_ADDR + 64*offset}.
- Done descriptor: ID=DONE_ID, single=1, immediate=1, dwords=1, dst=cpu_f2c_tail_addr, src={32'h0, zero-pad, new_tail}.
- Valid/ready: a descriptor is consumed in a cycle with valid&&ready. data and valid are held stable until consumed; valid drops the cycle after the last consume.
- FSM states:
  - IDLE: in_ready=1. A flit with in_sop → FILL, with flit_cnt=0. Non-sop flits in IDLE are discarded.
  - FILL: in_ready=1.
    - Each accepted flit is written next cycle: ep_write=1, ep_address=flit_cnt, ep_writedata=in_data. flit_cnt then increments.
    - Flits beyond MAX_FLITS are not written; the truncated flag is set.
    - in_eop → CHECK, with n=min(flit_cnt+1, MAX_FLITS). A single-flit packet (sop&&eop) goes directly to CHECK with n=1.
  - CHECK: in_ready=0.
    - free = (head - tail - 1) mod F2C_RB_DEPTH, computed in F2C_RB_AWIDTH bits.
    - Stall while n > free (ring full).
    - Otherwise new_tail = (tail + n) mod DEPTH.
    - If tail + n <= DEPTH → DESC, else → DESC_LOW.
  - DESC: data descriptor, dst=kmem_addr+64*tail, n flits, offset 0. On consume → DONE.
  - DESC_LOW: dst=kmem_addr+64*tail, DEPTH-tail flits, offset 0. On consume → DESC_HIGH.
  - DESC_HIGH: dst=kmem_addr, n-(DEPTH-tail) flits, offset DEPTH-tail. On consume → DONE. Back-to-back descriptors are allowed, with valid held high.
  - DONE: present the done descriptor. On consume:
    - tail<=new_tail
    - pkt_cnt++
    - drop_cnt++ if truncated
    - → IDLE
- The endpoint buffer is not overwritten before DONE, because in_ready=0 in CHECK/DESC*/DONE.
- tail == new_tail == 0 when a packet lands exactly at the ring end. This uses the DESC path, not a split.

Test Plan:
1. Reset, head=0; 4-flit packet → 4 ep writes (addr 0..3) → data desc: dwords=64, dst=kmem_addr, src=0x48000 → done desc with imm data 4; tail=4, pkt_cnt=1.
2. Wrap: tail=510, head=100, 5-flit packet → DESC_LOW (2 flits, dst kmem+64*510, src 0x48000), then DESC_HIGH (3 flits, dst kmem, src 0x48080) → done data 3; tail=3.
3. Exact end: tail=508, head=10, 4 flits → single DESC, dwords=64; tail=0.
4. Full: tail=10, head=12 (free=1), 3-flit packet → stall in CHECK, in_ready=0, no desc; set head=20 → proceeds; tail=13.
5. Backpressure: wrdm_desc_ready low for 10 cycles during DESC and DONE → valid and data stable throughout, exactly one consume each.
6. 40-flit packet → 32 ep writes, dwords=512, drop_cnt=1; rst asserted mid-DESC_HIGH → all outputs return to reset values, tail=0.
